sram_arbiter: RTL and testbench

Sequences and shares the single SDRAM controller port between the three requesters in the Spectrum host: ioctl download writes, Z80 memory cycles, and tape sample reads hidden in refresh slots. Replaces ad-hoc top-level priority muxing with a registered grant FSM, a one-entry ioctl write buffer, and a tape request/acknowledge handshake. It sits between the CPU, data_io, tape and the sram controller.

---
 rtl/sram_arb_pkg.sv | 34 +++
 rtl/sync2.sv | 26 ++
 rtl/sram_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SDRAM port arbiter.
// The arbiter FSM states, the owner codes shown on the owner output, the
// address/data widths of the memory port and the default abort timeout.
package sram_arb_pkg;

  localparam int ADDR_W          = 25;
  localparam int DATA_W          = 8;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_IOCTL_CYC = 2'd1,
    ST_CPU_CYC   = 2'd2,
    ST_TAPE_CYC  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IOCTL = 2'd1,
    OWN_CPU   = 2'd2,
    OWN_TAPE  = 2'd3
  } owner_t;

  // Grant code reported for each arbiter state.
  function automatic owner_t owner_of(input arb_state_t s);
    case (s)
      ST_IOCTL_CYC: return OWN_IOCTL;
      ST_CPU_CYC:   return OWN_CPU;
      ST_TAPE_CYC:  return OWN_TAPE;
      default:      return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with asynchronous active-low reset.
// Used to bring the Z80 nRFSH strobe into the system clock domain; the reset
// value lets the idle level of the synchronized signal be chosen per use.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  // Two-stage capture; q is the second stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      q        <= RESET_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single SDRAM controller port between ioctl
// download writes, Z80 memory cycles and tape reads hidden in refresh slots.
// Registered grant FSM, one-entry ioctl write buffer, tape req/ack handshake
// and a per-cycle abort timer.
// Optional feature macro: SRAM_ARB_TAPE_CACHE_EN keeps the last completed
// tape address/data and answers a repeat tape_req from it without a memory
// cycle; without it every tape_req performs a memory cycle.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk_sys,
  input  logic              nRESET,
  input  logic              ioctl_req,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_data,
  input  logic              cpu_rd,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_wait,
  input  logic              nRFSH,
  input  logic              tape_req,
  input  logic [ADDR_W-1:0] tape_addr,
  output logic [DATA_W-1:0] tape_data,
  output logic              tape_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_ack,
  output logic [1:0]        owner,
  output logic              err_timeout,
  output logic              err_overrun
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  arb_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  tmo_cnt_reg;
  logic              rfsh_n_sync;
  logic              refresh_slot;

  logic              ibuf_full_reg;
  logic [ADDR_W-1:0] ibuf_addr_reg;
  logic [DATA_W-1:0] ibuf_data_reg;

  logic              cpu_served_reg;
  logic              cpu_pending;

  logic              tape_pending_reg;
  logic [ADDR_W-1:0] tape_addr_reg;

  logic              grant_ioctl, grant_cpu, grant_tape;
  logic              cyc_done, cyc_abort;
  logic              cpu_end, tape_done, tape_abort;
  logic              cache_hit;
  logic [DATA_W-1:0] hit_data;

  sync2 #(.RESET_VAL(1'b1)) u_rfsh_sync (
    .clk   (clk_sys),
    .rst_n (nRESET),
    .d     (nRFSH),
    .q     (rfsh_n_sync)
  );

  assign refresh_slot = ~rfsh_n_sync;
  assign cpu_pending  = (cpu_rd | cpu_we) & ~cpu_served_reg;
  assign cpu_wait     = cpu_pending;
  assign owner        = owner_of(state_reg);

  assign cpu_end    = (state_reg == ST_CPU_CYC) && (cyc_done || cyc_abort);
  assign tape_done  = (state_reg == ST_TAPE_CYC) && cyc_done;
  assign tape_abort = (state_reg == ST_TAPE_CYC) && cyc_abort;

  // State register.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Grant priority in IDLE; completion or abort of the running cycle.
  always_comb begin
    state_next  = state_reg;
    grant_ioctl = 1'b0;
    grant_cpu   = 1'b0;
    grant_tape  = 1'b0;
    cyc_done    = 1'b0;
    cyc_abort   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ibuf_full_reg) begin
          grant_ioctl = 1'b1;
          state_next  = ST_IOCTL_CYC;
        end else if (cpu_pending && !ioctl_req) begin
          grant_cpu  = 1'b1;
          state_next = ST_CPU_CYC;
        end else if (tape_pending_reg && refresh_slot && !ioctl_req) begin
          grant_tape = 1'b1;
          state_next = ST_TAPE_CYC;
        end
      end
      default: begin
        if (mem_ack) begin
          cyc_done   = 1'b1;
          state_next = ST_IDLE;
        end else if (tmo_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          cyc_abort  = 1'b1;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // Cycles spent waiting for mem_ack in the current access.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET)                 tmo_cnt_reg <= '0;
    else if (state_reg == ST_IDLE) tmo_cnt_reg <= '0;
    else                         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end

  // Memory port: loaded at grant, held until ack/abort, then strobes dropped.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
    end else if (grant_ioctl) begin
      mem_addr <= ibuf_addr_reg;
      mem_din  <= ibuf_data_reg;
      mem_we   <= 1'b1;
      mem_rd   <= 1'b0;
    end else if (grant_cpu) begin
      mem_addr <= cpu_addr;
      mem_din  <= cpu_din;
      mem_we   <= cpu_we;
      mem_rd   <= ~cpu_we;
    end else if (grant_tape) begin
      mem_addr <= tape_addr_reg;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      mem_rd   <= 1'b1;
    end else if (cyc_done || cyc_abort) begin
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
    end
  end

  // One-entry ioctl buffer; freed when its write is granted, so a strobe in
  // the grant cycle is accepted.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      ibuf_full_reg <= 1'b0;
      ibuf_addr_reg <= '0;
      ibuf_data_reg <= '0;
    end else begin
      if (grant_ioctl) ibuf_full_reg <= 1'b0;
      if (ioctl_wr && (!ibuf_full_reg || grant_ioctl)) begin
        ibuf_full_reg <= 1'b1;
        ibuf_addr_reg <= ioctl_addr;
        ibuf_data_reg <= ioctl_data;
      end
    end
  end

  // CPU served flag (one memory cycle per held request) and read data.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      cpu_served_reg <= 1'b0;
      cpu_dout       <= 8'hFF;
    end else begin
      if (!cpu_rd && !cpu_we) cpu_served_reg <= 1'b0;
      else if (cpu_end)       cpu_served_reg <= 1'b1;
      if (state_reg == ST_CPU_CYC) begin
        if (cyc_done && mem_rd) cpu_dout <= mem_dout;
        else if (cyc_abort)     cpu_dout <= 8'hFF;
      end
    end
  end

`ifdef SRAM_ARB_TAPE_CACHE_EN
  logic              cache_valid_reg;
  logic [ADDR_W-1:0] cache_addr_reg;
  logic [DATA_W-1:0] cache_data_reg;

  assign cache_hit = tape_req && cache_valid_reg && (tape_addr == cache_addr_reg);
  assign hit_data  = cache_data_reg;

  // Last completed tape read; any ioctl write may change memory, so drop it.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      cache_valid_reg <= 1'b0;
      cache_addr_reg  <= '0;
      cache_data_reg  <= '0;
    end else if (ioctl_wr) begin
      cache_valid_reg <= 1'b0;
    end else if (tape_done) begin
      cache_valid_reg <= 1'b1;
      cache_addr_reg  <= mem_addr;
      cache_data_reg  <= mem_dout;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = '0;
`endif

  // Tape request latch (latest address wins) and one-cycle ack with data.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      tape_pending_reg <= 1'b0;
      tape_addr_reg    <= '0;
      tape_data        <= '0;
      tape_ack         <= 1'b0;
    end else begin
      tape_ack <= 1'b0;
      if (tape_req) begin
        if (cache_hit) begin
          tape_pending_reg <= 1'b0;
        end else begin
          tape_pending_reg <= 1'b1;
          tape_addr_reg    <= tape_addr;
        end
      end else if (grant_tape) begin
        tape_pending_reg <= 1'b0;
      end
      if (tape_done) begin
        tape_data <= mem_dout;
        tape_ack  <= 1'b1;
      end else if (tape_abort) begin
        tape_data <= 8'hFF;
        tape_ack  <= 1'b1;
      end
      if (cache_hit) begin
        tape_data <= hit_data;
        tape_ack  <= 1'b1;
      end
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (cyc_abort) err_timeout <= 1'b1;
      if (ioctl_wr && ibuf_full_reg && !grant_ioctl) err_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios followed by a randomized mix of CPU,
// tape and ioctl accesses, checked against a bench-side memory model.
module tb_sram_arbiter;

  logic        clk_sys = 1'b0;
  logic        nRESET;
  logic        ioctl_req, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        cpu_rd, cpu_we;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_wait;
  logic        nRFSH;
  logic        tape_req;
  logic [24:0] tape_addr;
  logic [7:0]  tape_data;
  logic        tape_ack;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_we, mem_rd, mem_ack;
  logic [1:0]  owner;
  logic        err_timeout, err_overrun;

  int checks = 0;
  int errors = 0;

  always #18 clk_sys = ~clk_sys;

  sram_arbiter dut (
    .clk_sys(clk_sys), .nRESET(nRESET),
    .ioctl_req(ioctl_req), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait(cpu_wait), .nRFSH(nRFSH),
    .tape_req(tape_req), .tape_addr(tape_addr), .tape_data(tape_data), .tape_ack(tape_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .owner(owner),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  // ---------------- memory model and reference contents ----------------
  typedef struct { logic [1:0] own; logic we; logic [24:0] addr; logic [7:0] data; } cyc_t;
  cyc_t        cyc_log[$];
  logic [7:0]  sram[int];
  logic [7:0]  ref_mem[int];
  int          mem_cycles = 0;
  int          ack_delay = 1;
  bit          ack_disable = 0;
  bit          mc_valid = 0;
  logic [24:0] mc_addr;
  logic [7:0]  mc_data;

  function automatic logic [7:0] pattern(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sram_rd(input logic [24:0] a);
    if (sram.exists(int'(a))) return sram[int'(a)];
    return pattern(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [24:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pattern(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SDRAM controller model: acks after ack_delay cycles, checks port stability.
  initial begin
    int          busy_cnt;
    logic [24:0] cyc_addr;
    busy_cnt = 0;
    mem_ack  = 1'b0;
    mem_dout = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_rd || mem_we) begin
        if (busy_cnt == 0) begin
          cyc_addr = mem_addr;
          check("rd_we_exclusive", 32'(mem_rd & mem_we), 32'd0);
        end else begin
          check("addr_stable", 32'(mem_addr), 32'(cyc_addr));
        end
        busy_cnt++;
        if (!ack_disable && busy_cnt >= ack_delay) begin
          if (mem_we) sram[int'(mem_addr)] = mem_din;
          else        mem_dout = sram_rd(mem_addr);
          cyc_log.push_back('{own: owner, we: mem_we, addr: mem_addr,
                              data: mem_we ? mem_din : mem_dout});
          mem_cycles++;
          mem_ack  = 1'b1;
          busy_cnt = 0;
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #(36 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- transaction tasks ----------------
  task automatic ioctl_write(input logic [24:0] a, input logic [7:0] d);
    int t;
    ioctl_req = 1'b1; ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    t = 0;
    while (!(mem_we && mem_addr == a) && t < 50) begin @(negedge clk_sys); t++; end
    check("ioctl_grant", 32'(t < 50), 32'd1);
    t = 0;
    while (owner != 2'd0 && t < 100) begin @(negedge clk_sys); t++; end
    check("ioctl_done", 32'(t < 100), 32'd1);
    ioctl_req = 1'b0;
    ref_mem[int'(a)] = d;
    mc_valid = 0;
    $display("ioctl write addr=%h data=%h", a, d);
  endtask

  task automatic cpu_access(input bit we, input logic [24:0] a, input logic [7:0] d,
                            output logic [7:0] rdata);
    int t;
    cpu_addr = a; cpu_din = d; cpu_we = we; cpu_rd = ~we;
    @(negedge clk_sys);
    check("cpu_wait_asserted", 32'(cpu_wait), 32'd1);
    t = 0;
    while (cpu_wait && t < 200) begin @(negedge clk_sys); t++; end
    check("cpu_done", 32'(t < 200), 32'd1);
    rdata = cpu_dout;
    cpu_rd = 1'b0; cpu_we = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic tape_read(input logic [24:0] a, output logic [7:0] rdata);
    int t;
    tape_addr = a; tape_req = 1'b1;
    @(negedge clk_sys);
    tape_req = 1'b0;
    t = 0;
    while (!tape_ack && t < 200) begin @(negedge clk_sys); t++; end
    check("tape_ack_seen", 32'(t < 200), 32'd1);
    rdata = tape_data;
    @(negedge clk_sys);
    check("tape_ack_width", 32'(tape_ack), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  r, r2, exp_d;
    logic [24:0] a;
    logic [7:0]  d;
    int          t, base, cyc0;
    bit          saw, cpu_ok, tape_ok;

    nRESET = 1'b0; ioctl_req = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_data = '0;
    cpu_rd = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0; nRFSH = 1'b1;
    tape_req = 0; tape_addr = '0;
    repeat (3) @(negedge clk_sys);

    // Reset state
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
    check("rst_tape_data", 32'(tape_data), 32'd0);
    check("rst_tape_ack", 32'(tape_ack), 32'd0);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_err_overrun", 32'(err_overrun), 32'd0);
    nRESET = 1'b1;
    repeat (2) @(negedge clk_sys);

    // ioctl write with ack 3 cycles later
    ack_delay = 3;
    ioctl_req = 1'b1; ioctl_addr = 25'h000100; ioctl_data = 8'hA5; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    t = 0;
    while (!mem_we && t < 20) begin @(negedge clk_sys); t++; end
    check("t1_grant", 32'(t < 20), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'h000100);
    check("t1_mem_din", 32'(mem_din), 32'hA5);
    check("t1_owner", 32'(owner), 32'd1);
    check("t1_mem_rd", 32'(mem_rd), 32'd0);
    t = 0;
    while (owner != 2'd0 && t < 20) begin @(negedge clk_sys); t++; end
    check("t1_done", 32'(t < 20), 32'd1);
    check("t1_sram", 32'(sram_rd(25'h000100)), 32'hA5);
    check("t1_overrun", 32'(err_overrun), 32'd0);
    ioctl_req = 1'b0; ref_mem[32'h100] = 8'hA5;
    $display("ioctl write addr=000100 data=a5");

    // CPU read, request held past completion
    ack_delay = 2;
    sram[32'h14000] = 8'h3C; ref_mem[32'h14000] = 8'h3C;
    cyc0 = mem_cycles;
    cpu_addr = 25'h014000; cpu_rd = 1'b1;
    @(negedge clk_sys);
    check("t2_wait_high", 32'(cpu_wait), 32'd1);
    t = 0;
    while (cpu_wait && t < 50) begin @(negedge clk_sys); t++; end
    check("t2_done", 32'(t < 50), 32'd1);
    check("t2_cpu_dout", 32'(cpu_dout), 32'h3C);
    repeat (6) @(negedge clk_sys);
    check("t2_single_cycle", 32'(mem_cycles - cyc0), 32'd1);
    check("t2_wait_low", 32'(cpu_wait), 32'd0);
    cpu_rd = 1'b0;
    @(negedge clk_sys);
    $display("cpu read addr=014000 data=%h", cpu_dout);

    // Tape read waits for the refresh slot
    tape_addr = 25'h180000; tape_req = 1'b1;
    @(negedge clk_sys);
    tape_req = 1'b0;
    saw = 0;
    repeat (10) begin
      @(negedge clk_sys);
      saw = saw | (owner == 2'd3) | mem_rd;
    end
    check("t3_no_grant", 32'(saw), 32'd0);
    nRFSH = 1'b0;
    t = 0;
    while (!tape_ack && t < 30) begin @(negedge clk_sys); t++; end
    check("t3_ack", 32'(t < 30), 32'd1);
    check("t3_tape_data", 32'(tape_data), 32'(ref_rd(25'h180000)));
    @(negedge clk_sys);
    check("t3_ack_width", 32'(tape_ack), 32'd0);
    mc_valid = 1; mc_addr = 25'h180000; mc_data = ref_rd(25'h180000);
    $display("tape read addr=180000 data=%h", tape_data);

    // CPU and tape become eligible in the same cycle: CPU first
    ioctl_req = 1'b1;
    tape_addr = 25'h002346; tape_req = 1'b1; cpu_addr = 25'h002345; cpu_rd = 1'b1;
    @(negedge clk_sys);
    tape_req = 1'b0;
    repeat (4) @(negedge clk_sys);
    base = cyc_log.size();
    ioctl_req = 1'b0;
    cpu_ok = 0; tape_ok = 0;
    for (int i = 0; i < 100 && !(cpu_ok && tape_ok); i++) begin
      @(negedge clk_sys);
      if (!cpu_wait && !cpu_ok) begin cpu_ok = 1; r = cpu_dout; end
      if (tape_ack) begin tape_ok = 1; r2 = tape_data; end
    end
    check("t4_both_done", 32'({cpu_ok, tape_ok}), 32'd3);
    check("t4_two_cycles", 32'(cyc_log.size() - base), 32'd2);
    if (cyc_log.size() >= base + 2) begin
      check("t4_first_cpu", 32'(cyc_log[base].own), 32'd2);
      check("t4_second_tape", 32'(cyc_log[base + 1].own), 32'd3);
    end
    check("t4_cpu_data", 32'(r), 32'(ref_rd(25'h002345)));
    check("t4_tape_data", 32'(r2), 32'(ref_rd(25'h002346)));
    cpu_rd = 1'b0; nRFSH = 1'b1;
    mc_valid = 1; mc_addr = 25'h002346; mc_data = ref_rd(25'h002346);
    @(negedge clk_sys);
    $display("cpu read 002345=%h then tape read 002346=%h", r, r2);

    // CPU read that is never acknowledged
    ack_disable = 1;
    cpu_addr = 25'h003000; cpu_rd = 1'b1;
    repeat (30) @(negedge clk_sys);
    check("t5_no_early_timeout", 32'(err_timeout), 32'd0);
    check("t5_still_waiting", 32'(cpu_wait), 32'd1);
    t = 0;
    while (cpu_wait && t < 100) begin @(negedge clk_sys); t++; end
    check("t5_released", 32'(t < 100), 32'd1);
    check("t5_err_timeout", 32'(err_timeout), 32'd1);
    check("t5_cpu_dout", 32'(cpu_dout), 32'hFF);
    check("t5_mem_rd_low", 32'(mem_rd), 32'd0);
    check("t5_owner", 32'(owner), 32'd0);
    cpu_rd = 1'b0; ack_disable = 0;
    @(negedge clk_sys);
    $display("cpu read addr=003000 aborted data=%h", cpu_dout);

    // Overrun: two more strobes while the first write is still in flight
    ack_delay = 6;
    ioctl_req = 1'b1;
    ioctl_addr = 25'h000200; ioctl_data = 8'h11; ioctl_wr = 1'b1;
    @(negedge clk_sys); ioctl_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    ioctl_addr = 25'h000201; ioctl_data = 8'h22; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_addr = 25'h000202; ioctl_data = 8'h33;
    @(negedge clk_sys); ioctl_wr = 1'b0;
    check("t6_overrun", 32'(err_overrun), 32'd1);
    repeat (40) @(negedge clk_sys);
    check("t6_first", 32'(sram_rd(25'h000200)), 32'h11);
    check("t6_second", 32'(sram_rd(25'h000201)), 32'h22);
    check("t6_dropped", 32'(sram.exists(32'h202)), 32'd0);
    ioctl_req = 1'b0;
    ref_mem[32'h200] = 8'h11; ref_mem[32'h201] = 8'h22; mc_valid = 0;
    $display("ioctl writes 000200/000201 kept, 000202 dropped");

`ifdef SRAM_ARB_TAPE_CACHE_EN
    // Repeat tape read of the same address comes from the cache
    nRFSH = 1'b0; ack_delay = 2;
    repeat (3) @(negedge clk_sys);
    tape_read(25'h003100, r);
    check("t7_fill", 32'(r), 32'(ref_rd(25'h003100)));
    cyc0 = mem_cycles;
    tape_addr = 25'h003100; tape_req = 1'b1;
    @(negedge clk_sys);
    tape_req = 1'b0;
    check("t7_hit_ack", 32'(tape_ack), 32'd1);
    check("t7_hit_data", 32'(tape_data), 32'(ref_rd(25'h003100)));
    check("t7_no_mem_rd", 32'(mem_rd), 32'd0);
    repeat (3) @(negedge clk_sys);
    check("t7_no_cycle", 32'(mem_cycles - cyc0), 32'd0);
    mc_valid = 1; mc_addr = 25'h003100; mc_data = ref_rd(25'h003100);
    $display("tape cache hit addr=003100 data=%h", tape_data);
`endif

    // Randomized mix against the reference memory
    nRFSH = 1'b0;
    repeat (3) @(negedge clk_sys);
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind      = $urandom_range(0, 3);
      a         = 25'h001000 + 25'($urandom_range(0, 7));
      d         = 8'($urandom);
      ack_delay = $urandom_range(1, 4);
      cyc0      = mem_cycles;
      case (kind)
        0: begin
          cpu_access(1'b0, a, 8'h00, r);
          check("rnd_cpu_rd", 32'(r), 32'(ref_rd(a)));
          check("rnd_cpu_rd_cycles", 32'(mem_cycles - cyc0), 32'd1);
          $display("rnd %0d cpu read addr=%h data=%h", i, a, r);
        end
        1: begin
          cpu_access(1'b1, a, d, r);
          ref_mem[int'(a)] = d;
          check("rnd_cpu_wr_cycles", 32'(mem_cycles - cyc0), 32'd1);
          check("rnd_cpu_wr_mem", 32'(sram_rd(a)), 32'(d));
          $display("rnd %0d cpu write addr=%h data=%h", i, a, d);
        end
        2: begin
          tape_read(a, r);
`ifdef SRAM_ARB_TAPE_CACHE_EN
          if (mc_valid && mc_addr == a) exp_d = mc_data;
          else exp_d = ref_rd(a);
`else
          exp_d = ref_rd(a);
`endif
          check("rnd_tape_rd", 32'(r), 32'(exp_d));
          mc_valid = 1; mc_addr = a; mc_data = exp_d;
          $display("rnd %0d tape read addr=%h data=%h", i, a, r);
        end
        default: begin
          ioctl_write(a, d);
          check("rnd_ioctl_mem", 32'(sram_rd(a)), 32'(d));
        end
      endcase
    end

    check("end_timeout_sticky", 32'(err_timeout), 32'd1);
    check("end_overrun_sticky", 32'(err_overrun), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
